// File: rtl/bsg_bypass_fifo_reader_pkg.sv
// Shared helpers for the bypass FIFO reader: pointer sizing for arbitrary depths.
package bsg_bypass_fifo_reader_pkg;

  // A single-entry buffer still needs a 1-bit pointer to index storage.
  function automatic int ptr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/bsg_bypass_fifo_ptr.sv
// Wrapping circular-buffer pointer; wraps at els_p-1 with no gap for non-power-of-two depths.
module bsg_bypass_fifo_ptr
  import bsg_bypass_fifo_reader_pkg::*;
#(
  parameter int els_p = 2,
  localparam int ptr_w_lp = ptr_width(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                incr_i,
  output logic [ptr_w_lp-1:0] ptr_o
);

  logic [ptr_w_lp-1:0] r_ptr;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (incr_i) begin
      r_ptr <= (r_ptr == ptr_w_lp'(els_p - 1)) ? '0 : r_ptr + ptr_w_lp'(1);
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/bsg_bypass_fifo_reader.sv
// Consumer-side ready/valid buffer: zero-latency bypass when empty and taken, else in-order replay.
// ready_o depends on occupancy only, so a full buffer cannot enqueue on the cycle it is drained.
module bsg_bypass_fifo_reader
  import bsg_bypass_fifo_reader_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 2,
  localparam int lg_els_lp = $clog2(els_p + 1),
  localparam int ptr_w_lp  = ptr_width(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 v_i,
  input  logic [width_p-1:0]   data_i,
  output logic                 ready_o,
  output logic                 v_o,
  output logic [width_p-1:0]   data_o,
  input  logic                 yumi_i,
  output logic [lg_els_lp-1:0] count_o
);

  logic [width_p-1:0]   r_mem [els_p];
  logic [lg_els_lp-1:0] r_count;
  logic [ptr_w_lp-1:0]  w_rptr;
  logic [ptr_w_lp-1:0]  w_wptr;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_enq;
  logic                 w_bypass;
  logic                 w_write;
  logic                 w_read;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == lg_els_lp'(els_p));
  assign w_enq    = v_i & ~w_full;
  assign w_bypass = w_empty & v_i & yumi_i;
  assign w_write  = w_enq & ~w_bypass;
  assign w_read   = yumi_i & ~w_empty;

  assign ready_o = ~w_full;
  assign v_o     = v_i | ~w_empty;
  assign data_o  = w_empty ? data_i : r_mem[w_rptr];
  assign count_o = r_count;

  bsg_bypass_fifo_ptr #(.els_p(els_p)) u_rptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .incr_i  (w_read),
    .ptr_o   (w_rptr)
  );

  bsg_bypass_fifo_ptr #(.els_p(els_p)) u_wptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .incr_i  (w_write),
    .ptr_o   (w_wptr)
  );

  // Storage contents are don't-care after reset; occupancy alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[w_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (w_write & ~w_read) begin
      r_count <= r_count + lg_els_lp'(1);
    end else if (~w_write & w_read) begin
      r_count <= r_count - lg_els_lp'(1);
    end
  end

`ifndef SYNTHESIS
  logic r_stalled_v;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_stalled_v <= 1'b0;
    end else begin
      r_stalled_v <= v_i & ~ready_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o is low");
      assert (r_count <= lg_els_lp'(els_p)) else $error("occupancy above depth");
      if (r_stalled_v && !v_i) $warning("producer dropped v_i while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_bypass_fifo_reader.sv
// Directed and randomised checks of bsg_bypass_fifo_reader at depths 1, 2, 3 and 5.
module tb_bsg_bypass_fifo_reader;

  localparam int N = 4;

  function automatic int els_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i     [N];
  logic        yumi_i  [N];
  logic        ready_o [N];
  logic        v_o     [N];
  logic [31:0] data_i  [N];
  logic [31:0] data_o  [N];
  logic [3:0]  count_o [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int E = els_of(g);
    logic [$clog2(E+1)-1:0] cnt;
    bsg_bypass_fifo_reader #(.width_p(32), .els_p(E)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .v_i     (v_i[g]),
      .data_i  (data_i[g]),
      .ready_o (ready_o[g]),
      .v_o     (v_o[g]),
      .data_o  (data_o[g]),
      .yumi_i  (yumi_i[g]),
      .count_o (cnt)
    );
    assign count_o[g] = 4'(cnt);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      v_i[k] = 1'b0; yumi_i[k] = 1'b0; data_i[k] = '0;
    end
  endtask

  logic [31:0] q [N][$];
  logic        pend [N];
  logic        mv   [N];
  int          p, e, sz;
  logic        acc, byp;

  initial begin
    rst = 1'b1;
    idle_all();
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_count", 32'(count_o[k]), 0);
      chk("rst_ready", 32'(ready_o[k]), 1);
      chk("rst_v", 32'(v_o[k]), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Bypass on depth 2
    v_i[1] = 1'b1; data_i[1] = 32'hA5A5_0001; yumi_i[1] = 1'b1;
    #2;
    chk("byp_v", 32'(v_o[1]), 1);
    chk("byp_data", data_o[1], 32'hA5A5_0001);
    chk("byp_ready", 32'(ready_o[1]), 1);
    tick();
    chk("byp_count", 32'(count_o[1]), 0);

    // Fill and stall
    v_i[1] = 1'b1; data_i[1] = 32'h11; yumi_i[1] = 1'b0;
    tick();
    chk("fill_count1", 32'(count_o[1]), 1);
    chk("fill_head1", data_o[1], 32'h11);
    data_i[1] = 32'h22;
    tick();
    chk("fill_count2", 32'(count_o[1]), 2);
    chk("fill_ready", 32'(ready_o[1]), 0);
    data_i[1] = 32'h33;
    tick();
    chk("stall_count", 32'(count_o[1]), 2);
    chk("stall_head", data_o[1], 32'h11);

    // Drain: 33 stays offered but cannot enter while full
    yumi_i[1] = 1'b1;
    #2;
    chk("drain_d0", data_o[1], 32'h11);
    tick();
    chk("drain_count1", 32'(count_o[1]), 1);
    chk("drain_ready", 32'(ready_o[1]), 1);
    v_i[1] = 1'b0;
    #2;
    chk("drain_d1", data_o[1], 32'h22);
    tick();
    chk("drain_count0", 32'(count_o[1]), 0);
    yumi_i[1] = 1'b0;
    #1;
    chk("drain_v_idle", 32'(v_o[1]), 0);
    v_i[1] = 1'b1; data_i[1] = 32'h77;
    #1;
    chk("drain_v_follow", 32'(v_o[1]), 1);
    chk("drain_d_follow", data_o[1], 32'h77);
    v_i[1] = 1'b0;
    tick();

    // Streaming with wrap on depth 3
    p = 1; e = 1;
    for (int c = 0; c < 20; c++) begin
      v_i[2]    = (p <= 8);
      data_i[2] = 32'(p);
      yumi_i[2] = (c >= 2) && (e <= 8);
      #2;
      acc = v_i[2] && ((p - e) < 3);
      if (yumi_i[2]) begin
        chk("wrap_data", data_o[2], 32'(e));
        e++;
      end
      if (acc) p++;
      tick();
      if (c >= 2 && c <= 7) chk("wrap_count", 32'(count_o[2]), 2);
    end
    chk("wrap_all", 32'(e), 9);
    idle_all();
    tick();

    // Asynchronous reset with two entries queued
    v_i[1] = 1'b1; data_i[1] = 32'h44;
    tick();
    data_i[1] = 32'h55;
    tick();
    v_i[1] = 1'b0;
    #1;
    chk("ar_pre_count", 32'(count_o[1]), 2);
    #1 rst = 1'b1;
    #1;
    chk("ar_count", 32'(count_o[1]), 0);
    chk("ar_ready", 32'(ready_o[1]), 1);
    chk("ar_v_idle", 32'(v_o[1]), 0);
    v_i[1] = 1'b1; data_i[1] = 32'h5;
    #1;
    chk("ar_v_follow", 32'(v_o[1]), 1);
    chk("ar_d_follow", data_o[1], 32'h5);
    v_i[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    v_i[1] = 1'b1; data_i[1] = 32'hDEAD_BEEF; yumi_i[1] = 1'b1;
    #2;
    chk("ar_byp_v", 32'(v_o[1]), 1);
    chk("ar_byp_data", data_o[1], 32'hDEAD_BEEF);
    tick();
    chk("ar_byp_count", 32'(count_o[1]), 0);
    idle_all();

    // Random traffic on every depth against queue models
    #1 rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      pend[k] = 1'b0;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k]) begin
          v_i[k]    = 1'($urandom_range(0, 1));
          data_i[k] = $urandom;
        end
        mv[k]     = v_i[k] || (q[k].size() > 0);
        yumi_i[k] = mv[k] && ($urandom_range(0, 3) != 0);
      end
      #2;
      for (int k = 0; k < N; k++) begin
        sz = q[k].size();
        chk("rnd_v", 32'(v_o[k]), 32'(mv[k]));
        chk("rnd_ready", 32'(ready_o[k]), 32'(sz < els_of(k)));
        chk("rnd_count", 32'(count_o[k]), 32'(sz));
        if (yumi_i[k]) chk("rnd_data", data_o[k], (sz > 0) ? q[k][0] : data_i[k]);
        acc = v_i[k] && (sz < els_of(k));
        byp = (sz == 0) && v_i[k] && yumi_i[k];
        if (yumi_i[k] && sz > 0) void'(q[k].pop_front());
        if (acc && !byp) q[k].push_back(data_i[k]);
        pend[k] = v_i[k] && !acc;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
